fpga_ccff_loader: RTL and testbench
===================================

# fpga_ccff_loader

Wishbone-programmable bitstream loader that drives the FPGA fabric configuration chain (ccff_head, prog_clk, prog_reset) from the Caravel management SoC instead of external GPIOs. Software pushes 32-bit bitstream words into a small FIFO; the block serialises them MSB-first onto ccff_head with a divided prog_clk and, optionally, captures ccff_tail for readback. It sits in the user project wrapper alongside the fabric core as a Wishbone slave, behind the parent address decode.

## Interface
Parameters:
- CLK_DIV, 4 — prog_clk half-period in wb_clk_i cycles; legal 1..255.
- FIFO_DEPTH, 4 — bitstream word FIFO depth; power of two, 2..16.
- LEN_W, 20 — width of the bit-length register.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe/cycle/write.
- wbs_sel_i  in  4  ignored; all accesses are full-word.
- wbs_adr_i  in  32  only [3:2] decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered ack.
- wbs_dat_o  out  32  read data.
- prog_clk_o  out  1  configuration clock to fabric.
- prog_reset_o  out  1  configuration reset to fabric.
- ccff_head_o  out  1  configuration serial data to fabric.
- ccff_tail_i  in  1  configuration serial data from fabric.
- busy_o  out  1  high while state != IDLE/DONE.
- done_irq_o  out  1  one-cycle pulse on entering DONE.

## Operation
- Register map ([3:2]): 0 CTRL, 1 STATUS, 2 LEN, 3 DATA.
- CTRL write: bit0 start, bit1 prog_reset level (drives prog_reset_o directly), bit2 abort. Read: {29'b0, 1'b0, prog_reset, 1'b0}.
- STATUS read: bit0 busy, bit1 done (sticky), bit2 fifo_full, bit3 fifo_empty, bit4 overflow (sticky), [15:8] fifo level. Writes ignored; done and overflow cleared by start.
- LEN: RW, LEN_W bits, total bits to shift. Writes while busy ignored.
- DATA write: push word; if FIFO full, word dropped, overflow set. DATA read: readback register (see Configuration).
- FSM: IDLE -> (start) LOAD -> SHIFT_LO <-> SHIFT_HI -> DONE; WAIT entered from LOAD when FIFO empty.
- LOAD: pop FIFO into 32-bit shift register, bit index 31. Empty -> WAIT (prog_clk held low, no error) until a word arrives.
- SHIFT_LO: ccff_head_o = shreg[31] presented on entry; prog_clk_o low for CLK_DIV cycles, then SHIFT_HI.
- SHIFT_HI: prog_clk_o high CLK_DIV cycles; on exit bit counter +1, shreg <<= 1. Counter == LEN -> DONE; 32 bits of word consumed -> LOAD; else SHIFT_LO.
- LEN = 0: start -> DONE next cycle, no prog_clk edges, FIFO untouched.
- DONE: prog_clk low, ccff_head_o holds last bit; start re-arms from LOAD; leftover FIFO words retained.
- abort (any state): next cycle IDLE, prog_clk_o low, FIFO flushed, counter cleared; done not set. abort+start same write: abort wins.
- start while busy: ignored.

## Timing
- Reset values: wbs_ack_o 0, wbs_dat_o 0, prog_clk_o 0, prog_reset_o 0, ccff_head_o 0, busy_o 0, done_irq_o 0; FIFO empty, LEN 0, flags 0.
- Wishbone: ack asserted the cycle after stb&cyc sampled high, held one cycle; no ack in the following cycle (2-cycle minimum per access). Read data valid with ack.
- Start written in cycle N (ack N+1): LOAD at N+1, SHIFT_LO at N+2 with first bit on ccff_head_o, first prog_clk rise at N+2+CLK_DIV.
- Per bit: exactly 2*CLK_DIV cycles; full word with FIFO non-empty: 64*CLK_DIV + 1 cycles (one LOAD cycle between words).
- FIFO push and pop in same cycle when full: both succeed, no overflow.

## Configuration
- CCFF_READBACK_EN defined: in the last cycle of each SHIFT_HI, ccff_tail_i sampled and shifted into a 32-bit readback register LSB-in; cleared on start; DATA read returns it.
- Undefined: no readback register; DATA read returns 32'h0; ccff_tail_i unused.

## Test plan
- Reset: assert wb_rst_i 2 cycles -> all outputs 0, STATUS = 32'h0000_0008.
- LEN=8, DATA=32'hA500_0000, start, CLK_DIV=4 -> ccff_head_o shows 1,0,1,0,0,1,0,1 at 8 prog_clk rises spaced 8 cycles; done_irq_o pulses once; STATUS bit1 = 1.
- LEN=40, push one word, start, push second word 200 cycles later -> prog_clk held low in WAIT after 32 bits, resumes, 40 rises total.
- Push 5 words with FIFO_DEPTH=4 -> STATUS overflow=1, level=4; fifth word never shifted.
- Abort mid-word after 10 bits -> IDLE next cycle, prog_clk_o 0, fifo_empty=1, done=0.
- CCFF_READBACK_EN, ccff_tail_i looped to ccff_head_o through 1-stage model, LEN=32, word 32'h1234_5678 -> DATA read = 32'h1234_5678 (per model delay alignment).

Source files
------------

// File: rtl/fpga_ccff_loader.sv
// Wishbone-programmable loader: shifts FIFO'd bitstream words MSB-first onto the fabric config chain.
// Define CCFF_READBACK_EN to capture ccff_tail_i into a readback register visible at DATA.
module fpga_ccff_loader #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        prog_clk_o,
    output logic        prog_reset_o,
    output logic        ccff_head_o,
    input  logic        ccff_tail_i,
    output logic        busy_o,
    output logic        done_irq_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_SHIFT_LO, S_SHIFT_HI, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             ack_q;
    logic [31:0]      rdat_q;
    logic             progClk_q, progReset_q, doneIrq_q, done_q, overflow_q;
    logic [LEN_W-1:0] len_q, bitCnt_q, bitCntInc;
    logic [4:0]       wordBits_q;
    logic [7:0]       div_q, div_d;
    logic [31:0]      shreg_q;
    logic [31:0]      fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      readback, rdData;
    logic [1:0]       regSel;
    logic access, wrAcc, rdAcc, ctrlWr, lenWr, dataWr, abortReq, startGo, idleOrDone;
    logic fifoEmpty, fifoFull, pop, push, shiftStep, enterDone, divDone;

    assign access     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wrAcc      = access & wbs_we_i;
    assign rdAcc      = access & ~wbs_we_i;
    assign regSel     = wbs_adr_i[3:2];
    assign ctrlWr     = wrAcc && (regSel == 2'd0);
    assign lenWr      = wrAcc && (regSel == 2'd2);
    assign dataWr     = wrAcc && (regSel == 2'd3);
    assign idleOrDone = (state_q == S_IDLE) || (state_q == S_DONE);
    assign abortReq   = ctrlWr & wbs_dat_i[2];
    assign startGo    = ctrlWr & wbs_dat_i[0] & ~wbs_dat_i[2] & idleOrDone;
    assign fifoEmpty  = (count_q == '0);
    assign fifoFull   = (count_q == DEPTH_C);
    assign push       = dataWr & (~fifoFull | pop);
    assign divDone    = (div_q == DIV_LAST);
    assign bitCntInc  = bitCnt_q + LEN_W'(1);

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = rdat_q;
    assign prog_clk_o   = progClk_q;
    assign prog_reset_o = progReset_q;
    assign ccff_head_o  = shreg_q[31];
    assign busy_o       = ~idleOrDone;
    assign done_irq_o   = doneIrq_q;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        shiftStep = 1'b0;
        enterDone = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (startGo) begin
                    if (len_q == '0) begin
                        state_d   = S_DONE;
                        enterDone = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (fifoEmpty) begin
                    state_d = S_WAIT;
                end else begin
                    pop     = 1'b1;
                    state_d = S_SHIFT_LO;
                end
            end
            S_WAIT:     if (!fifoEmpty) state_d = S_LOAD;
            S_SHIFT_LO: if (divDone) state_d = S_SHIFT_HI;
            S_SHIFT_HI: begin
                if (divDone) begin
                    shiftStep = 1'b1;
                    if (bitCntInc == len_q) begin
                        state_d   = S_DONE;
                        enterDone = 1'b1;
                    end else if (wordBits_q == 5'd31) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_SHIFT_LO;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abortReq) begin
            state_d   = S_IDLE;
            pop       = 1'b0;
            shiftStep = 1'b0;
            enterDone = 1'b0;
        end
    end

    // Divider restarts on every state change so each prog_clk phase lasts exactly CLK_DIV cycles.
    always_comb begin
        div_d = '0;
        if ((state_d == state_q) && ((state_q == S_SHIFT_LO) || (state_q == S_SHIFT_HI)))
            div_d = div_q + 8'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            progClk_q   <= 1'b0;
            progReset_q <= 1'b0;
            doneIrq_q   <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            len_q       <= '0;
            bitCnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            progClk_q <= (state_d == S_SHIFT_HI);
            doneIrq_q <= enterDone;
            if (ctrlWr) progReset_q <= wbs_dat_i[1];
            if (lenWr && idleOrDone) len_q <= wbs_dat_i[LEN_W-1:0];
            if (startGo || abortReq) bitCnt_q <= '0;
            else if (shiftStep) bitCnt_q <= bitCntInc;
            if (startGo) begin
                done_q     <= 1'b0;
                overflow_q <= 1'b0;
            end
            if (enterDone) done_q <= 1'b1;
            if (dataWr && fifoFull && !pop) overflow_q <= 1'b1;
        end
    end

    // The final bit and the last bit of a word are not shifted away, so ccff_head_o holds them.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shreg_q    <= '0;
            wordBits_q <= '0;
        end else if (pop) begin
            shreg_q    <= fifoMem[rdPtr_q];
            wordBits_q <= '0;
        end else if (shiftStep) begin
            wordBits_q <= wordBits_q + 5'd1;
            if (state_d == S_SHIFT_LO) shreg_q <= {shreg_q[30:0], 1'b0};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) fifoMem[wrPtr_q] <= wbs_dat_i;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || abortReq) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop) rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        rdData = '0;
        case (regSel)
            2'd0:    rdData = {30'b0, progReset_q, 1'b0};
            2'd1:    rdData = {16'b0, 8'(count_q), 3'b0, overflow_q, fifoEmpty, fifoFull,
                               done_q, busy_o};
            2'd2:    rdData = 32'(len_q);
            default: rdData = readback;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
            ack_q  <= access;
            rdat_q <= rdAcc ? rdData : 32'h0;
        end
    end

`ifdef CCFF_READBACK_EN
    logic [31:0] rb_q;
    logic [33:0] unusedBits;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || startGo) rb_q <= '0;
        else if (shiftStep) rb_q <= {rb_q[30:0], ccff_tail_i};
    end

    assign readback   = rb_q;
    assign unusedBits = {wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};
`else
    logic [34:0] unusedBits;

    assign readback   = 32'h0;
    assign unusedBits = {wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], ccff_tail_i};
`endif

endmodule

// File: tb/tb_fpga_ccff_loader.sv
// Self-checking bench for fpga_ccff_loader: a word/bit-queue model checks every prog_clk rise,
// while directed Wishbone sequences pin register values and timing with literal expectations.
module tb_fpga_ccff_loader;

   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 4;

   logic        wb_clk_i  = 1'b0;
   logic        wb_rst_i  = 1'b1;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_we_i  = 1'b0;
   logic [3:0]  wbs_sel_i = 4'hF;
   logic [31:0] wbs_adr_i = '0;
   logic [31:0] wbs_dat_i = '0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        prog_clk_o, prog_reset_o, ccff_head_o, busy_o, done_irq_o;
   logic        ccffTail = 1'b0;

   int passCount = 0;
   int checkCount = 0;
   int cycleCnt = 0;
   int lastEdge = 0;

   // Model of the configuration stream: FIFO contents, current word and bits left to shift
   logic [31:0] mWords[$];
   logic [31:0] mCur = '0;
   int mCurLeft = 0;
   int mRemain = 0;
   int mLen = 0;
   int runRises = 0;
   int firstRiseCyc = -1;
   int startEdge = 0;
   int lastRise = 0;
   int irqCount = 0;
   logic [31:0] obsBits = '0;
   logic prevClk = 1'b0;
   logic prevIrq = 1'b0;

   fpga_ccff_loader #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .LEN_W(20)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .prog_clk_o(prog_clk_o), .prog_reset_o(prog_reset_o),
      .ccff_head_o(ccff_head_o), .ccff_tail_i(ccffTail),
      .busy_o(busy_o), .done_irq_o(done_irq_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(posedge wb_clk_i) cycleCnt++;

   // One-flop fabric chain clocked by prog_clk, feeding the tail back
   always @(posedge prog_clk_o) ccffTail <= ccff_head_o;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Every prog_clk rise must carry the next model bit, spaced 2*CLK_DIV within a word
   always @(negedge wb_clk_i) begin
      if (!wb_rst_i) begin
         if (prog_clk_o && !prevClk) begin
            runRises++;
            if (runRises == 1) firstRiseCyc = cycleCnt;
            obsBits = {obsBits[30:0], ccff_head_o};
            checkOutput("rise_allowed", {31'b0, mRemain != 0}, 32'd1);
            if (mRemain != 0) begin
               if (mCurLeft == 0) begin
                  checkOutput("model_word_avail", {31'b0, mWords.size() != 0}, 32'd1);
                  if (mWords.size() != 0) mCur = mWords.pop_front();
                  mCurLeft = 32;
               end else begin
                  checkOutput("bit_spacing", cycleCnt - lastRise, 2 * CLK_DIV);
               end
               checkOutput("ccff_head_bit", {31'b0, ccff_head_o}, {31'b0, mCur[31]});
               mCur = mCur << 1;
               mCurLeft--;
               mRemain--;
            end
            lastRise = cycleCnt;
         end
         if (done_irq_o) begin
            irqCount++;
            checkOutput("done_at_len", mRemain, 0);
            checkOutput("irq_single_cycle", {31'b0, prevIrq}, 32'd0);
         end
         prevClk = prog_clk_o;
         prevIrq = done_irq_o;
      end
   end

   task automatic applyStimulus(input bit we, input int idx, input logic [31:0] wdat,
                                output logic [31:0] rdat);
      @(posedge wb_clk_i); #1;
      wbs_stb_i = 1'b1;
      wbs_cyc_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = 32'(idx) << 2;
      wbs_dat_i = wdat;
      @(posedge wb_clk_i); #1;
      lastEdge = cycleCnt;
      rdat = wbs_dat_o;
      checkOutput("wb_ack", {31'b0, wbs_ack_o}, 32'd1);
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_we_i  = 1'b0;
   endtask

   task automatic wbWrite(input int idx, input logic [31:0] d);
      logic [31:0] dummy;
      applyStimulus(1'b1, idx, d, dummy);
   endtask

   task automatic wbRead(input int idx, output logic [31:0] d);
      applyStimulus(1'b0, idx, 32'h0, d);
   endtask

   task automatic pushWord(input logic [31:0] w);
      wbWrite(3, w);
      if (mWords.size() < DEPTH) mWords.push_back(w);
   endtask

   task automatic setLen(input int n);
      wbWrite(2, n);
      mLen = n;
   endtask

   task automatic startRun();
      wbWrite(0, 32'h1);
      startEdge = lastEdge;
      mRemain = mLen;
      mCurLeft = 0;
      runRises = 0;
      firstRiseCyc = -1;
      obsBits = '0;
   endtask

   task automatic abortRun();
      wbWrite(0, 32'h4);
      mWords.delete();
      mRemain = 0;
      mCurLeft = 0;
   endtask

   task automatic waitIrq(input int budget, input string name);
      int n = 0;
      int base = irqCount;
      while (irqCount == base && n < budget) begin
         @(posedge wb_clk_i);
         n++;
      end
      #1;
      checkOutput(name, irqCount - base, 1);
   endtask

   task automatic waitRises(input int target, input int budget);
      int n = 0;
      while (runRises < target && n < budget) begin
         @(posedge wb_clk_i);
         n++;
      end
      checkOutput("rises_reached", runRises, target);
   endtask

   initial begin
      logic [31:0] rd;
      int irqBefore;

      repeat (2) @(posedge wb_clk_i);
      #1;
      checkOutput("reset_outputs", {26'b0, wbs_ack_o, prog_clk_o, prog_reset_o, ccff_head_o,
                                    busy_o, done_irq_o}, 32'h0);
      checkOutput("reset_dat_o", wbs_dat_o, 32'h0);
      wb_rst_i = 1'b0;
      wbRead(1, rd);
      checkOutput("reset_status", rd, 32'h0000_0008);
      wbRead(2, rd);
      checkOutput("reset_len", rd, 32'h0);

      // Eight bits of 0xA5 at CLK_DIV=4
      setLen(8);
      wbRead(2, rd);
      checkOutput("len_readback", rd, 32'd8);
      pushWord(32'hA500_0000);
      startRun();
      waitIrq(200, "irq_len8");
      checkOutput("first_rise_latency", firstRiseCyc - startEdge, 1 + CLK_DIV);
      checkOutput("rises_len8", runRises, 8);
      checkOutput("bits_len8", obsBits, 32'h0000_00A5);
      checkOutput("head_holds_last", {31'b0, ccff_head_o}, 32'd1);
      checkOutput("busy_after_done", {31'b0, busy_o}, 32'd0);
      wbRead(1, rd);
      checkOutput("status_done", rd, 32'h0000_000A);

      wbWrite(0, 32'h2);
      checkOutput("prog_reset_set", {31'b0, prog_reset_o}, 32'd1);
      wbRead(0, rd);
      checkOutput("ctrl_readback", rd, 32'h0000_0002);
      wbWrite(0, 32'h0);
      checkOutput("prog_reset_clr", {31'b0, prog_reset_o}, 32'd0);

      // 40 bits with only one word queued: stall in WAIT, then resume
      setLen(40);
      pushWord(32'hDEAD_BEEF);
      startRun();
      repeat (300) @(posedge wb_clk_i);
      #1;
      checkOutput("wait_clk_low", {31'b0, prog_clk_o}, 32'd0);
      checkOutput("wait_busy", {31'b0, busy_o}, 32'd1);
      checkOutput("wait_rises", runRises, 32);
      wbRead(1, rd);
      checkOutput("wait_status", rd, 32'h0000_0009);
      pushWord(32'hC300_0000);
      waitIrq(400, "irq_len40");
      checkOutput("rises_len40", runRises, 40);

      // LEN=0 finishes immediately without touching the FIFO
      setLen(0);
      pushWord(32'h0F0F_1234);
      startRun();
      waitIrq(4, "irq_len0");
      checkOutput("rises_len0", runRises, 0);
      wbRead(1, rd);
      checkOutput("status_len0", rd, 32'h0000_0102);

      // Fifth queued word overflows and is dropped
      pushWord(32'h8000_0001);
      pushWord(32'h5555_AAAA);
      pushWord(32'hFFFF_0000);
      pushWord(32'h1357_9BDF);
      wbRead(1, rd);
      checkOutput("status_overflow", rd, 32'h0000_0416);
      setLen(128);
      startRun();
      waitIrq(1500, "irq_len128");
      checkOutput("rises_len128", runRises, 128);
      wbRead(1, rd);
      checkOutput("status_after_128", rd, 32'h0000_000A);

      // Abort after ten bits
      setLen(64);
      pushWord(32'hCAFE_F00D);
      pushWord(32'h0123_4567);
      startRun();
      waitRises(10, 200);
      irqBefore = irqCount;
      abortRun();
      @(posedge wb_clk_i); #1;
      checkOutput("abort_busy", {31'b0, busy_o}, 32'd0);
      checkOutput("abort_clk", {31'b0, prog_clk_o}, 32'd0);
      wbRead(1, rd);
      checkOutput("abort_status", rd, 32'h0000_0008);
      repeat (20) @(posedge wb_clk_i);
      #1;
      checkOutput("abort_no_irq", irqCount - irqBefore, 0);
      checkOutput("abort_no_rises", runRises, 10);

      // Tail readback through the one-flop chain
      setLen(32);
      pushWord(32'h1234_5678);
      startRun();
      waitIrq(400, "irq_len32");
      wbRead(3, rd);
`ifdef CCFF_READBACK_EN
      checkOutput("data_readback", rd, 32'h1234_5678);
`else
      checkOutput("data_readback", rd, 32'h0);
`endif

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
               passCount, checkCount);
      $fatal(1, "[TB] watchdog");
   end

endmodule
